video_source_switch: RTL and testbench

VIDEO_SOURCE_SWITCH -- requirements
Module: video_source_switch

---
 rtl/video_source_switch.sv | 153 +++++++++++++++
 tb/tb_video_source_switch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_source_switch.sv
// Video source switch: free-running 640x480 fallback timing, core lock/select.
// Optional core-vsync watchdog enabled by VIDEO_SOURCE_SWITCH_TIMEOUT_EN.
module video_source_switch #(
   parameter logic [23:0] FB_COLOR   = 24'hFFFFFF,
   parameter int unsigned LOCK_EDGES = 3,
   parameter int unsigned TIMEOUT_W  = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] core_r,
   input  logic [7:0] core_g,
   input  logic [7:0] core_b,
   input  logic       core_hs,
   input  logic       core_vs,
   input  logic       core_de,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_de,
   output logic       core_active,
   output logic       core_lost
);

   typedef enum logic {SEEK = 1'b0, CORE = 1'b1} state_e;

   localparam logic [2:0] LOCK = 3'(LOCK_EDGES);

   state_e     state_q, state_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [2:0] edges_q, edges_d;
   logic [2:0] edges_inc;
   logic       vs_prev_q;
   logic       vs_edge;
   logic       timeout;
   logic       lost_d;

   logic        fb_hs, fb_vs, fb_de;
   logic [23:0] fb_col;
   logic [23:0] rgb_d;
   logic        hs_d, vs_d, de_d;

   assign vs_edge   = core_vs & ~vs_prev_q;
   assign edges_inc = edges_q + 3'd1;

   always_comb begin
      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
      if (hcnt_q == 10'd799) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == 10'd524) ? '0 : vcnt_q + 10'd1;
      end
   end

   assign fb_hs  = (hcnt_q >= 10'd656) && (hcnt_q <= 10'd751);
   assign fb_vs  = (vcnt_q >= 10'd490) && (vcnt_q <= 10'd491);
   assign fb_de  = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
   assign fb_col = fb_de ? FB_COLOR : 24'h000000;

`ifdef VIDEO_SOURCE_SWITCH_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd_q, wd_d;

   assign timeout = &wd_q;

   always_comb begin
      wd_d = wd_q + 1'b1;
      if (vs_edge)
         wd_d = '0;
      else if (timeout)
         wd_d = wd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`else
   // No watchdog: never times out for any legal width.
   assign timeout = (TIMEOUT_W == 0);
`endif

   always_comb begin
      state_d = state_q;
      edges_d = edges_q;
      lost_d  = 1'b0;
      unique case (state_q)
         SEEK: begin
            if (vs_edge) begin
               edges_d = edges_inc;
               if (edges_inc == LOCK) state_d = CORE;
            end else if (timeout) begin
               edges_d = '0;
            end
         end
         CORE: begin
            if (!vs_edge && timeout) begin
               state_d = SEEK;
               edges_d = '0;
               lost_d  = 1'b1;
            end
         end
      endcase
   end

   // Output mux follows the next state so a switch lands on the locking edge.
   always_comb begin
      rgb_d = fb_col;
      hs_d  = fb_hs;
      vs_d  = fb_vs;
      de_d  = fb_de;
      if (state_d == CORE) begin
         rgb_d = {core_r, core_g, core_b};
         hs_d  = core_hs;
         vs_d  = core_vs;
         de_d  = core_de;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SEEK;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         edges_q     <= '0;
         vs_prev_q   <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b0;
         vga_vs      <= 1'b0;
         vga_de      <= 1'b0;
         core_active <= 1'b0;
         core_lost   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         edges_q     <= edges_d;
         vs_prev_q   <= core_vs;
         vga_r       <= rgb_d[23:16];
         vga_g       <= rgb_d[15:8];
         vga_b       <= rgb_d[7:0];
         vga_hs      <= hs_d;
         vga_vs      <= vs_d;
         vga_de      <= de_d;
         core_active <= (state_d == CORE);
         core_lost   <= lost_d;
      end
   end

endmodule

// File: tb/tb_video_source_switch.sv
// Bench for video_source_switch: scoreboarded per-cycle output check
// plus directed checks of lock, timeout and reset behaviour.
module tb_video_source_switch;

   localparam int TW    = 10;
   localparam int WDMAX = (1 << TW) - 1;
`ifdef VIDEO_SOURCE_SWITCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cr = '0, cg = '0, cb = '0;
   logic       chs = 1'b0, cvs = 1'b0, cde = 1'b0;

   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, vga_de, core_active, core_lost;
   logic [7:0] r1, g1, b1;
   logic       hs1, vs1, de1, act1, lost1;

   video_source_switch #(
      .FB_COLOR(24'hFFFFFF), .LOCK_EDGES(3), .TIMEOUT_W(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .core_r(cr), .core_g(cg), .core_b(cb),
      .core_hs(chs), .core_vs(cvs), .core_de(cde),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .core_active(core_active), .core_lost(core_lost)
   );

   video_source_switch #(
      .FB_COLOR(24'hFFFFFF), .LOCK_EDGES(1), .TIMEOUT_W(TW)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .core_r(cr), .core_g(cg), .core_b(cb),
      .core_hs(chs), .core_vs(cvs), .core_de(cde),
      .vga_r(r1), .vga_g(g1), .vga_b(b1),
      .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1),
      .core_active(act1), .core_lost(lost1)
   );

   always #5 clk = ~clk;

   typedef logic [28:0] vec_t;
   vec_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   int mh, mv, mcnt, mwd;
   bit mcore, mprev;

   function automatic vec_t dut_vec();
      return {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
              core_active, core_lost};
   endfunction

   function automatic vec_t dut1_vec();
      return {r1, g1, b1, hs1, vs1, de1, act1, lost1};
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mh = 0; mv = 0; mcnt = 0; mwd = 0; mcore = 0; mprev = 0;
   endtask

   task automatic tick();
      bit          ev, to, ncore, lost;
      int          ncnt;
      logic        hs, vs, de;
      logic [23:0] col;
      vec_t        e;
      ev    = cvs && !mprev;
      to    = TO_EN && (mwd == WDMAX);
      ncore = mcore;
      ncnt  = mcnt;
      lost  = 0;
      if (!mcore) begin
         if (ev) begin
            ncnt = mcnt + 1;
            if (ncnt == 3) ncore = 1;
         end else if (to) begin
            ncnt = 0;
         end
      end else if (to && !ev) begin
         ncore = 0; ncnt = 0; lost = 1;
      end
      hs  = (mh >= 656) && (mh <= 751);
      vs  = (mv >= 490) && (mv <= 491);
      de  = (mh < 640) && (mv < 480);
      col = de ? 24'hFFFFFF : 24'h0;
      if (ncore) e = {cr, cg, cb, chs, cvs, cde, 1'b1, lost};
      else       e = {col, hs, vs, de, 1'b0, lost};
      sb.push_back(e);
      @(posedge clk);
      mcore = ncore;
      mcnt  = ncnt;
      mprev = cvs;
      if (ev)               mwd = 0;
      else if (mwd < WDMAX) mwd = mwd + 1;
      if (mh == 799) begin
         mh = 0;
         mv = (mv == 524) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
      #1;
      check("out", dut_vec(), sb.pop_front());
      cyc++;
      {cr, cg, cb} = 24'($urandom);
      chs = 1'($urandom_range(0, 1));
      cde = 1'($urandom_range(0, 1));
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   task automatic pulse(int gap);
      cvs = 1'b1;
      repeat (4) tick();
      cvs = 1'b0;
      run(gap);
   endtask

   initial begin
      int hs_at, lock_cyc, lost_cyc, lost_cnt;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", dut_vec(), 0);
      check("rst_out1", dut1_vec(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      hs_at = 0;
      for (int i = 1; i <= 1700; i++) begin
         tick();
         if (vga_hs && hs_at == 0) hs_at = i;
      end
      check("hs_first", hs_at, 657);
      check("seek_act", core_active, 0);

      lock_cyc = 0;
      for (int k = 0; k < 3; k++) begin
         cvs = 1'b1;
         check("pre_edge_act", core_active, 0);
         tick();
         if (k == 0) check("lock1_act", act1, 1);
         check("edge_act", core_active, k == 2);
         lock_cyc = cyc;
         repeat (3) tick();
         cvs = 1'b0;
         run(500);
      end
      run(200);
      check("core_pass_act", core_active, 1);

`ifdef VIDEO_SOURCE_SWITCH_TIMEOUT_EN
      lost_cyc = 0;
      lost_cnt = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (core_lost) begin
            lost_cnt++;
            if (lost_cyc == 0) lost_cyc = cyc;
         end
      end
      check("lost_delay", lost_cyc - lock_cyc, 1024);
      check("lost_width", lost_cnt, 1);
      check("lost_act", core_active, 0);
      pulse(300);
      pulse(1100);
      pulse(300);
      pulse(300);
      check("seek_after_gap", core_active, 0);
      cvs = 1'b1;
      tick();
      check("relock_act", core_active, 1);
      repeat (3) tick();
      cvs = 1'b0;
      run(50);
`else
      lost_cnt = 0;
      lost_cyc = lock_cyc;
      for (int i = 0; i < 1500; i++) begin
         tick();
         if (core_lost) lost_cnt++;
      end
      check("no_lost", lost_cnt, 0);
      check("core_latched", core_active, 1);
`endif

      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", dut_vec(), 0);
      check("rst_async1", dut1_vec(), 0);
      @(posedge clk);
      #1;
      check("rst_hold", dut_vec(), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      hs_at = 0;
      for (int i = 1; i <= 700; i++) begin
         tick();
         if (vga_hs && hs_at == 0) hs_at = i;
      end
      check("hs_restart", hs_at, 657);
      check("restart_act", core_active, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
